// File: rtl/pcd_fdt_check.sv
// pcd_fdt_check: ISO/IEC 14443-3 Type A (106 kbit/s) PCD-side frame delay time checker
module pcd_fdt_check #(
    parameter int COUNTER_WIDTH = 12,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int TIMING_ADJUST = 0,
    parameter int TOLERANCE     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pause_n,
    input  logic                     last_tx_bit,
    input  logic                     tx_done,
    input  logic                     picc_mod_edge,
    output logic                     busy,
    output logic                     result_valid,
    output logic [COUNTER_WIDTH-1:0] fdt_ticks,
    output logic                     fdt_ok,
    output logic                     fdt_early,
    output logic                     timeout
);
    localparam int W = COUNTER_WIDTH;
    localparam int E0 = 1172;
    localparam int E1 = 1236;
    localparam logic [W-1:0]        TO   = TIMEOUT_TICKS[W-1:0];
    localparam logic [W:0]          ADJ  = TIMING_ADJUST[W:0];
    localparam logic signed [W+1:0] TOL  = TOLERANCE[W+1:0];
    localparam logic signed [W+1:0] EXP0 = E0[W+1:0];
    localparam logic signed [W+1:0] EXP1 = E1[W+1:0];

    typedef enum logic [1:0] {IDLE, TX, WAIT, DONE} state_t;
    state_t state, state_next;
    logic pause_q, last_bit, rise, take_result, hit_timeout;
    logic [W-1:0] cnt, ticks, fdt_next;
    logic [W:0] adj;
    logic signed [W+1:0] expected, diff;

    assign rise         = pause_n && !pause_q;
    assign ticks        = rise ? '0 : (&cnt ? cnt : cnt + 1'b1);
    assign adj          = {1'b0, ticks} + ADJ;
    assign fdt_next     = adj[W] ? '1 : adj[W-1:0];
    assign expected     = last_bit ? EXP1 : EXP0;
    assign diff         = $signed({2'b00, fdt_next}) - expected;
    assign busy         = (state == TX) || (state == WAIT);
    assign result_valid = (state == DONE);

    // next state: a new pause in WAIT aborts, and a response beats a coincident timeout
    always_comb begin
        state_next  = state;
        take_result = 1'b0;
        hit_timeout = 1'b0;
        case (state)
            IDLE: state_next = pause_n ? IDLE : TX;
            TX:   state_next = tx_done ? WAIT : TX;
            WAIT: begin
                if (!pause_n) begin
                    state_next = TX;
                end else if (picc_mod_edge) begin
                    state_next  = DONE;
                    take_result = 1'b1;
                end else if (ticks >= TO) begin
                    state_next  = IDLE;
                    hit_timeout = 1'b1;
                end
            end
            DONE:    state_next = pause_n ? IDLE : TX;
            default: state_next = IDLE;
        endcase
    end

    // state, pause history, tick counter, latched last bit and timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pause_q  <= 1'b1;
            cnt      <= '0;
            last_bit <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            pause_q  <= pause_n;
            cnt      <= ticks;
            timeout  <= hit_timeout;
            if (state == TX && tx_done) last_bit <= last_tx_bit;
        end
    end

    // result registers hold until the next completed measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            fdt_ticks <= '0;
            fdt_ok    <= 1'b0;
            fdt_early <= 1'b0;
        end else if (take_result) begin
            fdt_ticks <= fdt_next;
            fdt_ok    <= (diff <= TOL) && (diff >= -TOL);
            fdt_early <= diff < -TOL;
        end
    end
endmodule

// File: tb/tb_pcd_fdt_check.sv
// tb_pcd_fdt_check: scoreboard bench for pcd_fdt_check with TIMING_ADJUST 0 and 4 instances
module tb_pcd_fdt_check;
    typedef struct {int ticks; bit ok; bit early; int cyc;} res_t;

    logic clk = 0, rst = 1, pause_n = 1, last_tx_bit = 0, tx_done = 0, picc_mod_edge = 0;
    logic [1:0] busy, rv, ok, early, to;
    logic [11:0] ft [2];
    int n_chk = 0, n_fail = 0, cyc = 0;
    res_t q [2][$];
    int tq [2][$];
    res_t e;

    pcd_fdt_check #(.TIMING_ADJUST(0)) dut0 (
        .clk(clk), .rst(rst), .pause_n(pause_n), .last_tx_bit(last_tx_bit),
        .tx_done(tx_done), .picc_mod_edge(picc_mod_edge), .busy(busy[0]),
        .result_valid(rv[0]), .fdt_ticks(ft[0]), .fdt_ok(ok[0]),
        .fdt_early(early[0]), .timeout(to[0])
    );
    pcd_fdt_check #(.TIMING_ADJUST(4)) dut4 (
        .clk(clk), .rst(rst), .pause_n(pause_n), .last_tx_bit(last_tx_bit),
        .tx_done(tx_done), .picc_mod_edge(picc_mod_edge), .busy(busy[1]),
        .result_valid(rv[1]), .fdt_ticks(ft[1]), .fdt_ok(ok[1]),
        .fdt_early(early[1]), .timeout(to[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every result or timeout pulse must match the head of its queue
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rv[d]) begin
                if (q[d].size() == 0) begin
                    chk($sformatf("dut%0d unexpected result_valid", d), 1, 0);
                end else begin
                    e = q[d].pop_front();
                    chk($sformatf("dut%0d fdt_ticks", d), int'(ft[d]), e.ticks);
                    chk($sformatf("dut%0d fdt_ok", d), int'(ok[d]), int'(e.ok));
                    chk($sformatf("dut%0d fdt_early", d), int'(early[d]), int'(e.early));
                    chk($sformatf("dut%0d result cycle", d), cyc, e.cyc);
                end
            end
            if (to[d]) begin
                if (tq[d].size() == 0) chk($sformatf("dut%0d unexpected timeout", d), 1, 0);
                else chk($sformatf("dut%0d timeout cycle", d), cyc, tq[d].pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d busy", tag, d), int'(busy[d]), 0);
            chk($sformatf("%s dut%0d result_valid", tag, d), int'(rv[d]), 0);
            chk($sformatf("%s dut%0d fdt_ticks", tag, d), int'(ft[d]), 0);
            chk($sformatf("%s dut%0d fdt_ok", tag, d), int'(ok[d]), 0);
            chk($sformatf("%s dut%0d fdt_early", tag, d), int'(early[d]), 0);
            chk($sformatf("%s dut%0d timeout", tag, d), int'(to[d]), 0);
        end
    endtask

    task automatic pulse(input int low, input int high, input bit edge_in_gap);
        pause_n = 0;
        repeat (low) tick;
        pause_n = 1;
        picc_mod_edge = edge_in_gap;
        tick;
        picc_mod_edge = 0;
        repeat (high - 1) tick;
    endtask

    // last pause of plen ticks, tx_done on its rise, PICC edge k ticks after the rise
    task automatic measure(input bit lb, input int plen, input int k, input bit abort_edge,
                           input bit edge_at_done, input int t0, input bit ok0, input bit e0,
                           input int t4, input bit ok4, input bit e4);
        int c;
        res_t r;
        pause_n = 0;
        picc_mod_edge = abort_edge;
        tick;
        picc_mod_edge = 0;
        repeat (plen - 1) tick;
        pause_n = 1;
        tx_done = 1;
        last_tx_bit = lb;
        picc_mod_edge = edge_at_done;
        tick;
        c = cyc;
        tx_done = 0;
        picc_mod_edge = 0;
        last_tx_bit = ~lb;
        r = '{t0, ok0, e0, c + k};
        q[0].push_back(r);
        r = '{t4, ok4, e4, c + k};
        q[1].push_back(r);
        repeat (k - 1) tick;
        picc_mod_edge = 1;
        tick;
        picc_mod_edge = 0;
        repeat (3) tick;
    endtask

    initial begin
        int c;
        repeat (3) tick;
        chk_zero("reset");
        rst = 0;
        tick;
        tx_done = 1;
        last_tx_bit = 1;
        tick;
        tx_done = 0;
        tick;
        chk("tx_done in idle busy", int'(busy[0]), 0);

        measure(0, 5, 1172, 0, 0, 1172, 1, 0, 1176, 0, 0);
        measure(1, 5, 1236, 0, 0, 1236, 1, 0, 1240, 0, 0);
        measure(0, 5, 1100, 0, 0, 1100, 0, 1, 1104, 0, 1);
        measure(0, 5, 1173, 0, 0, 1173, 0, 0, 1177, 0, 0);
        measure(1, 5, 4000, 0, 0, 4000, 0, 0, 4004, 0, 0);

        pulse(3, 1000, 1);
        pulse(1, 1, 0);
        pulse(2, 7, 1);
        measure(0, 4, 1172, 0, 1, 1172, 1, 0, 1176, 0, 0);

        pause_n = 0;
        repeat (2) tick;
        pause_n = 1;
        tx_done = 1;
        tick;
        tx_done = 0;
        repeat (500) tick;
        chk("wait busy", int'(busy[0]), 1);
        measure(1, 3, 1236, 1, 0, 1236, 1, 0, 1240, 0, 0);

        pause_n = 0;
        repeat (5) tick;
        pause_n = 1;
        tx_done = 1;
        last_tx_bit = 0;
        tick;
        c = cyc;
        tx_done = 0;
        tq[0].push_back(c + 4000);
        tq[1].push_back(c + 4000);
        tick;
        chk("pre-timeout busy", int'(busy[1]), 1);
        repeat (4010) tick;
        chk("post-timeout dut0 busy", int'(busy[0]), 0);
        chk("post-timeout dut4 busy", int'(busy[1]), 0);
        chk("held dut0 fdt_ticks", int'(ft[0]), 1236);
        chk("held dut0 fdt_ok", int'(ok[0]), 1);
        chk("held dut4 fdt_ticks", int'(ft[1]), 1240);

        pause_n = 0;
        repeat (5) tick;
        pause_n = 1;
        tx_done = 1;
        tick;
        tx_done = 0;
        repeat (599) tick;
        rst = 1;
        tick;
        rst = 0;
        chk_zero("mid-wait reset");
        repeat (50) tick;
        picc_mod_edge = 1;
        tick;
        picc_mod_edge = 0;
        repeat (10) tick;
        chk("after reset edge busy", int'(busy[0]), 0);

        measure(0, 5, 1168, 0, 0, 1168, 0, 1, 1172, 1, 0);

        repeat (20) tick;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d missing results", d), q[d].size(), 0);
            chk($sformatf("dut%0d missing timeouts", d), tq[d].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
